// File: rtl/game_pkg.sv
// Shared types and constants for the brick-game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        INIT  = 3'd1,
        AIM   = 3'd2,
        PLAY  = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    // Launch angles that move the ball straight along an axis.
    localparam logic [2:0] ANGLE_AXIS_A = 3'd1;
    localparam logic [2:0] ANGLE_AXIS_B = 3'd4;

endpackage

// File: rtl/period_calc.sv
// Ball-step period arithmetic: angle scaling with saturation, and the
// per-lap speed-up clamped at a minimum period.
module period_calc
    import game_pkg::*;
#(
    parameter int PERIOD_W   = 20,
    parameter int MIN_PERIOD = 20000
) (
    input  logic [PERIOD_W-1:0] base,
    input  logic [2:0]          angle,
    output logic [PERIOD_W-1:0] aim_period,
    output logic [PERIOD_W-1:0] next_base
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W:0]   sum;
    logic [PERIOD_W-1:0] reduced;

    always_comb begin
        // Diagonal launches travel further per step, so they get 1.5x the period.
        sum = {1'b0, base} + {2'b00, base[PERIOD_W-1:1]};
        if (angle == ANGLE_AXIS_A || angle == ANGLE_AXIS_B) begin
            aim_period = base;
        end else if (sum[PERIOD_W]) begin
            aim_period = '1;
        end else begin
            aim_period = sum[PERIOD_W-1:0];
        end

        reduced   = base - {2'b00, base[PERIOD_W-1:2]};
        next_base = (reduced < MIN_P) ? MIN_P : reduced;
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Brick-game phase sequencer: load/aim/play/pause/over, with lives,
// level, lap tracking and ball-step period generation.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = 5,
    parameter int MAX_LIFE    = 5,
    parameter int PERIOD_W    = 20,
    parameter int BASE_PERIOD = 120000,
    parameter int MIN_PERIOD  = 20000,
    parameter int LEVEL_W     = 3,
    parameter int LIFE_W      = 3,
    parameter int LAP_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                circle,
    input  logic                square,
    input  logic                dead,
    input  logic                win,
    input  logic [2:0]          angle,
    output logic [2:0]          state,
    output logic [LIFE_W-1:0]   life,
    output logic [LEVEL_W-1:0]  level,
    output logic [LAP_W-1:0]    lap,
    output logic [PERIOD_W-1:0] period,
    output logic                load
);

    localparam logic [PERIOD_W-1:0] BASE_P   = PERIOD_W'(BASE_PERIOD);
    localparam logic [LIFE_W-1:0]   LIFE_MAX = LIFE_W'(MAX_LIFE);
    localparam logic [LEVEL_W-1:0]  LVL_LAST = LEVEL_W'(NUM_LEVELS - 1);

    // All inputs are single-cycle strobes; one not consumed by the current
    // state is dropped on the spot and never remembered.
    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   base_q, base_d;
    logic [LIFE_W-1:0]     life_d;
    logic [LEVEL_W-1:0]    level_d;
    logic [LAP_W-1:0]      lap_d;
    logic [PERIOD_W-1:0]   period_d;
    logic [PERIOD_W-1:0]   aim_period, next_base;

    period_calc #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_period_calc (
        .base       (base_q),
        .angle      (angle),
        .aim_period (aim_period),
        .next_base  (next_base)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            life    <= '0;
            level   <= '0;
            lap     <= '0;
            period  <= BASE_P;
            load    <= 1'b0;
            base_q  <= BASE_P;
        end else begin
            state_q <= state_d;
            life    <= life_d;
            level   <= level_d;
            lap     <= lap_d;
            period  <= period_d;
            load    <= (state_d == INIT);
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:  state_d = INIT;
            INIT:  state_d = AIM;
            AIM:   if (circle) state_d = PLAY;
            PLAY: begin
                if (win)              state_d = INIT;
                else if (dead)        state_d = (life != '0) ? AIM : OVER;
                else if (square)      state_d = PAUSE;
            end
            PAUSE: if (square) state_d = PLAY;
            OVER:  if (square) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        life_d   = life;
        level_d  = level;
        lap_d    = lap;
        period_d = period;
        base_d   = base_q;
        case (state_q)
            LOAD: begin
                life_d = LIFE_MAX;
                base_d = BASE_P;
                lap_d  = '0;
            end
            AIM: period_d = aim_period;
            PLAY: begin
                if (win) begin
                    if (life < LIFE_MAX) life_d = life + 1'b1;
                    if (level == LVL_LAST) begin
                        level_d = '0;
                        if (lap != '1) lap_d = lap + 1'b1;
                        base_d  = next_base;
                    end else begin
                        level_d = level + 1'b1;
                    end
                end else if (dead && life != '0) begin
                    life_d = life - 1'b1;
                end
            end
            OVER: if (square) level_d = '0;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a randomized run
// against a behavioural model of the game rules.
module tb_game_flow_ctrl;

    localparam int PW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          circle = 1'b0, square = 1'b0, dead = 1'b0, win = 1'b0;
    logic [2:0]    angle = 3'd1;
    logic [2:0]    state;
    logic [2:0]    life;
    logic [2:0]    level;
    logic [3:0]    lap;
    logic [PW-1:0] period;
    logic          load;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model of the game rules, plain integers.
    int m_state, m_life, m_level, m_lap, m_base, m_period, m_load;
    logic [PW-1:0] exp_q[$];

    game_flow_ctrl dut (
        .clk(clk), .rst(rst), .circle(circle), .square(square), .dead(dead),
        .win(win), .angle(angle), .state(state), .life(life), .level(level),
        .lap(lap), .period(period), .load(load)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, c, s, d, w, input logic [2:0] a);
        int ns;
        if (r) begin
            m_state = 0; m_life = 0; m_level = 0; m_lap = 0;
            m_period = 120000; m_base = 120000; m_load = 0;
            return;
        end
        ns = m_state;
        case (m_state)
            0: begin m_life = 5; m_base = 120000; m_lap = 0; ns = 1; end
            1: ns = 2;
            2: begin
                if (a == 1 || a == 4) m_period = m_base;
                else m_period = (m_base * 3 / 2 > 1048575) ? 1048575 : m_base + m_base / 2;
                if (c) ns = 3;
            end
            3: begin
                if (w) begin
                    ns = 1;
                    m_life = (m_life + 1 > 5) ? 5 : m_life + 1;
                    if (m_level == 4) begin
                        m_level = 0;
                        m_lap = (m_lap == 15) ? 15 : m_lap + 1;
                        m_base = m_base - m_base / 4;
                        if (m_base < 20000) m_base = 20000;
                    end else m_level = m_level + 1;
                end else if (d) begin
                    if (m_life > 0) begin m_life = m_life - 1; ns = 2; end
                    else ns = 4;
                end else if (s) ns = 5;
            end
            5: if (s) ns = 3;
            4: if (s) begin ns = 0; m_level = 0; end
            default: ns = 0;
        endcase
        m_state = ns;
        m_load = (ns == 1) ? 1 : 0;
    endtask

    // Drive one cycle of inputs from a negedge, apply them at the posedge.
    task automatic step(input logic r, c, s, d, w, input logic [2:0] a);
        rst = r; circle = c; square = s; dead = d; win = w; angle = a;
        @(posedge clk);
        model_step(r, c, s, d, w, a);
        @(negedge clk);
        rst = 1'b0; circle = 1'b0; square = 1'b0; dead = 1'b0; win = 1'b0;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0, 3'd1);
        step(1, 0, 0, 0, 0, 3'd1);
        n_cmp++; if (state !== 3'd0 || life !== 3'd0 || level !== 3'd0 || lap !== 4'd0) begin
            n_fail++; $display("FAIL reset_regs: state=%0d life=%0d level=%0d lap=%0d want 0/0/0/0", state, life, level, lap);
        end
        n_cmp++; if (period !== 20'd120000 || load !== 1'b0) begin
            n_fail++; $display("FAIL reset_out: period=%0d load=%b want 120000/0", period, load);
        end
        step(0, 0, 0, 0, 0, 3'd1);
        n_cmp++; if (state !== 3'd1 || load !== 1'b1 || life !== 3'd5) begin
            n_fail++; $display("FAIL reset_init: state=%0d load=%b life=%0d want 1/1/5", state, load, life);
        end
        step(0, 0, 0, 0, 0, 3'd1);
        n_cmp++; if (state !== 3'd2 || load !== 1'b0 || period !== 20'd120000) begin
            n_fail++; $display("FAIL reset_aim: state=%0d load=%b period=%0d want 2/0/120000", state, load, period);
        end
    endtask

    task automatic test_aim_freeze;
        step(0, 0, 0, 0, 0, 3'd2);
        exp_q.push_back(20'd180000);
        step(0, 1, 0, 0, 0, 3'd2);
        n_cmp++; if (state !== 3'd3 || period !== exp_q[0]) begin
            n_fail++; $display("FAIL aim_launch: state=%0d period=%0d want 3/%0d", state, period, exp_q[0]);
        end
        step(0, 0, 0, 0, 0, 3'd1);
        n_cmp++; if (period !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL aim_frozen: period=%0d want 180000", period);
        end
    endtask

    task automatic test_pause;
        step(0, 0, 1, 0, 0, 3'd1);
        n_cmp++; if (state !== 3'd5) begin
            n_fail++; $display("FAIL pause_enter: state=%0d want 5", state);
        end
        step(0, 0, 0, 1, 0, 3'd1);
        n_cmp++; if (state !== 3'd5 || life !== 3'd5) begin
            n_fail++; $display("FAIL pause_dead: state=%0d life=%0d want 5/5", state, life);
        end
        step(0, 0, 1, 0, 0, 3'd1);
        n_cmp++; if (state !== 3'd3 || period !== 20'd180000) begin
            n_fail++; $display("FAIL pause_exit: state=%0d period=%0d want 3/180000", state, period);
        end
    endtask

    task automatic test_wins;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 3'd1);
            n_cmp++; if (state !== 3'd1 || load !== 1'b1 || level !== 3'((i + 1) % 5)) begin
                n_fail++; $display("FAIL win_%0d: state=%0d load=%b level=%0d want 1/1/%0d", i, state, load, level, (i + 1) % 5);
            end
            step(0, 0, 0, 0, 0, 3'd1);
            if (i < 4) step(0, 1, 0, 0, 0, 3'd1);
        end
        n_cmp++; if (lap !== 4'd1 || life !== 3'd5) begin
            n_fail++; $display("FAIL win_lap: lap=%0d life=%0d want 1/5", lap, life);
        end
        step(0, 0, 0, 0, 0, 3'd1);
        n_cmp++; if (period !== 20'd90000) begin
            n_fail++; $display("FAIL win_speedup: period=%0d want 90000", period);
        end
        step(0, 1, 0, 0, 0, 3'd1);
    endtask

    task automatic test_deaths;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 0, 3'd1);
            if (i < 5) begin
                n_cmp++; if (state !== 3'd2 || life !== 3'(4 - i)) begin
                    n_fail++; $display("FAIL death_%0d: state=%0d life=%0d want 2/%0d", i, state, life, 4 - i);
                end
                step(0, 1, 0, 0, 0, 3'd1);
            end
        end
        n_cmp++; if (state !== 3'd4) begin
            n_fail++; $display("FAIL death_over: state=%0d want 4", state);
        end
        step(0, 1, 0, 1, 1, 3'd1);
        n_cmp++; if (state !== 3'd4) begin
            n_fail++; $display("FAIL over_ignore: state=%0d want 4", state);
        end
        step(0, 0, 1, 0, 0, 3'd1);
        n_cmp++; if (state !== 3'd0) begin
            n_fail++; $display("FAIL over_restart: state=%0d want 0", state);
        end
        step(0, 0, 0, 0, 0, 3'd1);
        n_cmp++; if (state !== 3'd1 || level !== 3'd0 || life !== 3'd5) begin
            n_fail++; $display("FAIL restart_init: state=%0d level=%0d life=%0d want 1/0/5", state, level, life);
        end
    endtask

    task automatic test_floor;
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 0, 0, 0, 3'd1);
            step(0, 1, 0, 0, 0, 3'd1);
            n_cmp++; if (period !== PW'(m_base) || period < 20'd20000) begin
                n_fail++; $display("FAIL floor_%0d: period=%0d want %0d", i, period, m_base);
            end
            step(0, 0, 0, 0, 1, 3'd1);
        end
        step(0, 0, 0, 0, 0, 3'd1);
        step(0, 0, 0, 0, 0, 3'd1);
        n_cmp++; if (period !== 20'd20000 || lap !== 4'd15) begin
            n_fail++; $display("FAIL floor_final: period=%0d lap=%0d want 20000/15", period, lap);
        end
        step(0, 1, 0, 0, 0, 3'd1);
        step(0, 0, 1, 1, 1, 3'd1);
        n_cmp++; if (state !== 3'd1 || life !== 3'd5 || level !== 3'd1 || load !== 1'b1) begin
            n_fail++; $display("FAIL win_dead_same: state=%0d life=%0d level=%0d load=%b want 1/5/1/1", state, life, level, load);
        end
    endtask

    task automatic test_random;
        logic r, c, s, d, w;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 11) == 0);
            d = ($urandom_range(0, 19) == 0);
            w = ($urandom_range(0, 14) == 0);
            step(r, c, s, d, w, 3'($urandom_range(0, 7)));
            n_cmp++; if (state !== 3'(m_state) || life !== 3'(m_life) || level !== 3'(m_level)) begin
                n_fail++; $display("FAIL rand_%0d_st: state=%0d life=%0d level=%0d want %0d/%0d/%0d", i, state, life, level, m_state, m_life, m_level);
            end
            n_cmp++; if (lap !== 4'(m_lap) || period !== PW'(m_period) || load !== 1'(m_load)) begin
                n_fail++; $display("FAIL rand_%0d_out: lap=%0d period=%0d load=%b want %0d/%0d/%0d", i, lap, period, load, m_lap, m_period, m_load);
            end
        end
    endtask

    initial begin
        model_step(1, 0, 0, 0, 0, 3'd1);
        @(negedge clk);
        test_reset;
        test_aim_freeze;
        test_pause;
        test_wins;
        test_deaths;
        test_floor;
        step(1, 0, 0, 0, 0, 3'd1);
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised successor of the brick-game state controller. It sequences load, aim, play, pause and game-over phases, and tracks lives, level and laps through the level set. It derives the ball-step period from a per-lap base period and the launch angle. It sits between the key decoder (circle/square strobes) and the ball/brick engine (dead/win strobes), and drives the renderer and ball timer.

## Interface
Parameters:
- NUM_LEVELS, 5, number of levels per lap; level wraps to 0 after NUM_LEVELS-1
- MAX_LIFE, 5, life cap; also the starting life count
- PERIOD_W, 20, width of period outputs
- BASE_PERIOD, 120000, lap-0 base period in clocks
- MIN_PERIOD, 20000, floor for the base period after speed-ups
- LEVEL_W, 3, width of level; must satisfy 2^LEVEL_W >= NUM_LEVELS
- LIFE_W, 3, width of life; must satisfy 2^LIFE_W > MAX_LIFE
- LAP_W, 4, width of lap counter

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- circle  in  1  launch key, one-cycle strobe
- square  in  1  pause/restart key, one-cycle strobe
- dead  in  1  ball lost, one-cycle strobe
- win  in  1  all bricks cleared, one-cycle strobe
- angle  in  3  launch angle code; 1 and 4 are axis-aligned
- state  out  3  game state (encoding below)
- life  out  LIFE_W  remaining lives
- level  out  LEVEL_W  current level
- lap  out  LAP_W  completed laps, saturating
- period  out  PERIOD_W  ball step period in clocks
- load  out  1  one-cycle pulse: engine reloads brick layout for `level`

## Operation
- States: LOAD=0, INIT=1, AIM=2, PLAY=3, OVER=4, PAUSE=5. Codes 6 and 7 are illegal and go to LOAD next cycle.
- LOAD:
  - life <= MAX_LIFE
  - base <= BASE_PERIOD
  - lap <= 0
  - -> INIT
- INIT: load=1 for this cycle only; -> AIM.
- AIM:
  - Each cycle, period <= base if angle is 1 or 4, else base + (base>>1).
  - Sum is computed at PERIOD_W+1 bits and saturates to all-ones.
  - circle -> PLAY. period is frozen at the value registered on the circle cycle.
- PLAY, priority win > dead > square:
  - win:
    - -> INIT
    - life <= min(life+1, MAX_LIFE)
    - if level == NUM_LEVELS-1: level <= 0, lap <= lap+1 (saturating), base <= max(base - (base>>2), MIN_PERIOD)
    - otherwise level <= level+1
  - dead: if life > 0, life <= life-1 and -> AIM; otherwise -> OVER.
  - square: -> PAUSE.
- PAUSE:
  - square -> PLAY.
  - circle, dead and win are ignored.
  - period, life and level are held.
- OVER: square -> LOAD with level <= 0. All other inputs are ignored.
- Strobes arriving in a state that does not consume them are dropped, not queued.

## Timing
- Reset values:
  - state = LOAD
  - life = 0
  - level = 0
  - lap = 0
  - period = BASE_PERIOD
  - load = 0
  - internal base = BASE_PERIOD
- All outputs are registered. A transition occurs on the edge after the strobe is sampled high.
- Reset in any state, including mid-PLAY or PAUSE, returns every output to its reset value on the next edge.
- load asserts exactly one cycle, two cycles after leaving reset, and one cycle after every win.
- From reset deassertion, AIM is reached at the third edge.
- Simultaneous win and dead in PLAY are treated as win only.
- Simultaneous square with dead or win in PLAY: the dead or win is taken and square is dropped.

## Structure
- Package game_pkg holds:
  - state_t enum (LOAD..PAUSE with the codes above)
  - angle constants ANGLE_AXIS_A=1, ANGLE_AXIS_B=4
- Sub-module period_calc (combinational, parametrised by PERIOD_W) holds both pieces of period arithmetic:
  - angle scaling with saturation
  - speed-up with MIN_PERIOD floor
- The FSM instantiates period_calc once.

## Test plan
- Reset, then idle: state goes 0 -> 1 -> 2. Expect life=5, period=120000, load high only in the INIT cycle.
- Aim with angle=2, then circle: state=3, period=180000. Changing angle to 1 afterwards leaves period at 180000.
- In PLAY, square, then dead, then square: state 3 -> 5 -> 5 -> 3. life is unchanged by the dropped dead.
- Five wins starting from level 0:
  - level runs 1,2,3,4,0 and lap=1
  - next AIM with angle=1 gives period=90000
  - life stays 5, capped
- Six deaths from life=5: life counts down to 0, then state=4. square -> state 0, then 1; level=0, life=5.
- Force repeated laps: base reaches floor 20000 and never goes below. Assert win and dead in the same cycle: win path taken.
